pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised, stallable pipeline register chain with valid bits. It replaces the fixed per-boundary stage registers (fetch/decode, decode/execute, execute/memory, memory/writeback) of the 16-bit pipelined core with one generic block. It adds features the fixed registers lack:

- per-stage hold
- bubble collapsing
- ranged flush
- in/out valid-ready handshakes
- stall and bubble performance counters

It sits between the fetch unit (producer) and the writeback consumer.

## Interface
Parameters:
- STAGES, 4, number of register stages (≥2); stage 0 is youngest, stage STAGES-1 is oldest
- WIDTH, 16, payload bits per stage (instruction/PC/control bundle)
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  producer has an item on in_data
- in_data  input  WIDTH  producer payload
- in_ready  output  1  stage 0 accepts this cycle
- hold  input  STAGES  hold[i]=1: the valid occupant of stage i must not leave (multi-cycle op)
- flush  input  1  kill request
- flush_stage  input  $clog2(STAGES)  oldest stage index killed by flush
- out_valid  output  1  = stage_valid[STAGES-1]
- out_data  output  WIDTH  = payload of stage STAGES-1
- out_ready  input  1  consumer takes out_data this cycle
- stage_valid  output  STAGES  valid bit of each stage
- stage_data  output  STAGES*WIDTH  payload of each stage; stage i occupies bits [i*WIDTH +: WIDTH]
- clr_cnt  input  1  synchronous clear of both counters
- stall_cnt  output  CNT_W  cycles with in_valid & ~in_ready
- bubble_cnt  output  CNT_W  cycles with out_ready & ~out_valid

## Operation
Per-stage terms:
- rdy[STAGES] = out_ready.
- rdy[i] = ~valid[i] | (~hold[i] & rdy[i+1]).
- leave[i] = valid[i] & ~hold[i] & rdy[i+1].
- in_ready = rdy[0] & ~flush.

Stage updates at each edge, when not flushed:
- Stage i>0 with rdy[i]=1: loads valid[i] ← leave[i-1], data[i] ← data[i-1] when leave[i-1]=1. If leave[i-1]=0, the stage becomes a bubble.
- Stage 0 with rdy[0]=1: loads valid ← in_valid & in_ready, data ← in_data.
- Stage with rdy[i]=0: unchanged.

Rules:
- Bubble collapsing: an empty stage always accepts, even when downstream is blocked, so gaps close.
- hold on an invalid stage is ignored.
- Flush: at the edge, every item in stages 0..flush_stage is discarded.
  - Stages 0..flush_stage become invalid.
  - Stage flush_stage+1 receives a bubble if it advances.
  - No input is accepted that cycle.
  - Stages above flush_stage follow the normal rules.
  - flush_stage ≥ STAGES-1 clears the whole chain.
- Flush with hold: flush wins over hold inside the flushed range.
- Data of an invalid stage is not updated; its value carries no meaning.
- Counters:
  - Each counter increments by 1 on its condition and saturates at all-ones.
  - clr_cnt has priority over increment.
  - Counting stops during reset.

## Timing
- Reset (async, rst low): all stage_valid = 0, all stage_data = 0, both counters = 0.
  - Consequently in_ready = 1 (unless flush), out_valid = 0, out_data = 0.
  - Reset mid-operation drops all items immediately, without waiting for a clock edge.
- Latency with no holds: an item accepted at edge t is in stage 0 during cycle t+1 and appears on out_valid in cycle t+STAGES.
- Throughput: 1 item/cycle with no holds and out_ready held high.
- in_ready and out_valid are the only handshake outputs.
  - in_ready is a combinational function of hold, out_ready, flush and state; the path from out_ready to in_ready is combinational by design.
  - out_valid/out_data are registered.
- Producer must hold in_valid/in_data stable until accepted, except after a flush, which cancels the pending item.

## Structure
- Package pipe_pkg:
  - the FLUSH_W calculation helper ($clog2 with minimum 1)
  - the default payload field offsets (instr 15:0 for WIDTH=16 core use)
  - the counter saturation constant
- Sub-module pipe_slot: one stage, containing the valid flop, the WIDTH-bit data flop with load enable, and the flush-kill input. It is instantiated STAGES times with a generate loop.
- The ready chain and counters live in the top.

## Test plan
All scenarios use STAGES=4, WIDTH=16.

1. Streaming: out_ready=1, no hold, push 0x0001..0x0008 on consecutive cycles.
   - out_data = 0x0001 in cycle 5, then one item per cycle.
   - bubble_cnt = 4.
2. Hold: push 0xA000..0xA003 (one per stage), then hold[2]=1 for 3 cycles.
   - Stages 2/1/0 freeze.
   - Stage 3 drains 0xA000, then shows a bubble.
   - in_ready = 0 for 3 cycles; stall_cnt counts them if in_valid=1.
3. Bubble collapse: fill stages 3 and 0 only (0xB003, 0xB000) with out_ready=0.
   - 0xB000 advances to stage 1, then stage 2, then stops behind stage 3.
   - in_ready stays 1 throughout.
4. Flush: full chain 0xC000..0xC003, flush=1, flush_stage=1, in_valid=1, all in one cycle.
   - Next cycle: stages 0, 1 and 2 invalid; stage 3 holds the former stage-2 item.
   - in_ready = 0 in the flush cycle.
5. Back-pressure with counter saturation: CNT_W=4, in_valid=1, out_ready=0 for 30 cycles.
   - stall_cnt saturates at 0xF.
   - clr_cnt returns it to 0 on the next edge.
6. Async reset mid-stream: assert rst low between edges.
   - stage_valid = 0 and stage_data = 0 immediately, before the next edge.
   - in_ready = 1 once rst deasserts.

Source files
------------

// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants and helpers for the generic pipeline register chain.
package pipe_pkg;

    // Default payload layout for the 16-bit core: the instruction word fills the slot
    localparam int INSTR_LSB = 0;
    localparam int INSTR_MSB = 15;
    localparam int DEF_WIDTH = INSTR_MSB - INSTR_LSB + 1;

    // Performance counters stick at all-ones instead of wrapping
    localparam int DEF_CNT_W = 16;
    localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;

    // Width of the flush stage index; a 1-bit field is kept even for tiny chains
    function automatic int flush_w(input int stages);
        return ($clog2(stages) < 1) ? 1 : $clog2(stages);
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Producer/consumer handshake bundle of the pipeline chain.
interface pipe_stage_chain_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Environment side: drives the producer item and the consumer ready
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Chain side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_chain_slot.sv
// One pipeline slot: valid flop, payload flop with load enable, flush kill.
module pipe_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Valid bit: kill beats load; a slot that cannot load keeps its occupant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (kill) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= in_valid;
        end
    end

    // Payload moves only with a real item; bubbles leave stale data behind
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else if (!kill && load && in_valid) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Stallable pipeline register chain with per-stage hold, bubble collapsing,
// ranged flush and stall/bubble performance counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    pipe_stage_chain_if.slave             bus,
    input  logic [STAGES-1:0]             hold,
    input  logic                          flush,
    input  logic [flush_w(STAGES)-1:0]    flush_stage,
    output logic [STAGES-1:0]             stage_valid,
    output logic [STAGES*WIDTH-1:0]       stage_data,
    input  logic                          clr_cnt,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              bubble_cnt
);

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] kill;

    // Ready chain from the consumer back to stage 0, plus the flush kill range
    always_comb begin
        rdy          = '0;
        kill         = '0;
        rdy[STAGES]  = bus.out_ready;
        for (int unsigned j = 0; j < STAGES; j++) begin
            int unsigned i;
            i       = STAGES - 1 - j;
            rdy[i]  = ~stage_valid[i] | (~hold[i] & rdy[i+1]);
            kill[i] = flush & (32'(flush_stage) >= i);
        end
    end

    assign bus.in_ready  = rdy[0] & ~flush;
    assign bus.out_valid = stage_valid[STAGES-1];
    assign bus.out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        logic             ld_valid;
        logic [WIDTH-1:0] ld_data;

        if (g == 0) begin : g_head
            assign ld_valid = bus.in_valid & bus.in_ready;
            assign ld_data  = bus.in_data;
        end else begin : g_body
            // A killed upstream occupant arrives as a bubble
            assign ld_valid = stage_valid[g-1] & ~hold[g-1] & rdy[g] & ~kill[g-1];
            assign ld_data  = stage_data[(g-1)*WIDTH +: WIDTH];
        end

        pipe_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .kill     (kill[g]),
            .load     (rdy[g]),
            .in_valid (ld_valid),
            .in_data  (ld_data),
            .valid    (stage_valid[g]),
            .data     (stage_data[g*WIDTH +: WIDTH])
        );
    end

    // Producer stall counter, saturating, clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (bus.in_valid && !bus.in_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Consumer bubble counter, saturating, clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (clr_cnt) begin
            bubble_cnt <= '0;
        end else if (bus.out_ready && !bus.out_valid && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (STAGES=4, WIDTH=16).
module tb_pipe_stage_chain;

    localparam int STAGES = 4;
    localparam int WIDTH  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stage_chain_if #(.WIDTH(WIDTH)) bus ();
    pipe_stage_chain_if #(.WIDTH(WIDTH)) sbus ();

    logic [STAGES-1:0]       hold;
    logic                    flush;
    logic [1:0]              flush_stage;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic                    clr_cnt;
    logic [15:0]             stall_cnt;
    logic [15:0]             bubble_cnt;

    logic [STAGES-1:0]       s_valid;
    logic [STAGES*WIDTH-1:0] s_data;
    logic                    s_clr;
    logic [3:0]              s_stall;
    logic [3:0]              s_bubble;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_chain #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .hold(hold), .flush(flush),
        .flush_stage(flush_stage), .stage_valid(stage_valid), .stage_data(stage_data),
        .clr_cnt(clr_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_chain #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .bus(sbus.slave), .hold(4'b0000), .flush(1'b0),
        .flush_stage(2'b00), .stage_valid(s_valid), .stage_data(s_data),
        .clr_cnt(s_clr), .stall_cnt(s_stall), .bubble_cnt(s_bubble)
    );

    function automatic logic [WIDTH-1:0] sd(input int i);
        return stage_data[i*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.out_ready = 1'b0;
        hold = '0; flush = 1'b0; flush_stage = '0; clr_cnt = 1'b0; s_clr = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (stage_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_valid: got %b want 0000", stage_valid); end
        n_cmp++; if (stage_data !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", stage_data); end
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin n_bad++; $display("FAIL reset_out: got %b/%h want 0/0000", bus.out_valid, bus.out_data); end
        n_cmp++; if (stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", stall_cnt, bubble_cnt); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        flush = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
        flush = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(k);
            #1;
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready k=%0d: got %b want 1", k, bus.in_ready); end
            tick();
            if (k >= 4) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(k - 3)) begin n_bad++; $display("FAIL stream_out k=%0d: got %b/%h want 1/%h", k, bus.out_valid, bus.out_data, 16'(k - 3)); end
            end else begin
                n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early k=%0d: got out_valid %b want 0", k, bus.out_valid); end
            end
        end
        bus.in_valid = 1'b0;
        for (int k = 6; k <= 8; k++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(k)) begin n_bad++; $display("FAIL stream_drain: got %b/%h want 1/%h", bus.out_valid, bus.out_data, 16'(k)); end
        end
        n_cmp++; if (bubble_cnt !== 16'd4) begin n_bad++; $display("FAIL stream_bubble_cnt: got %0d want 4", bubble_cnt); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_hold();
        do_reset();
        for (int k = 0; k < 4; k++) push(16'hA000 + 16'(k));
        n_cmp++; if (stage_valid !== 4'b1111 || bus.out_data !== 16'hA000) begin n_bad++; $display("FAIL hold_fill: got %b/%h want 1111/a000", stage_valid, bus.out_data); end
        hold = 4'b0100;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hA004;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready c=%0d: got %b want 0", c, bus.in_ready); end
            tick();
            n_cmp++; if (stage_valid !== 4'b0111 || sd(2) !== 16'hA001 || sd(1) !== 16'hA002 || sd(0) !== 16'hA003) begin
                n_bad++; $display("FAIL hold_freeze c=%0d: got %b %h %h %h want 0111 a001 a002 a003", c, stage_valid, sd(2), sd(1), sd(0));
            end
        end
        n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL hold_stall_cnt: got %0d want 3", stall_cnt); end
        hold = '0;
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_collapse();
        logic [STAGES-1:0] exp_v [3];
        exp_v[0] = 4'b1010; exp_v[1] = 4'b1100; exp_v[2] = 4'b1100;
        do_reset();
        push(16'hB003);
        repeat (3) tick();
        n_cmp++; if (stage_valid !== 4'b1000) begin n_bad++; $display("FAIL collapse_seed: got %b want 1000", stage_valid); end
        bus.in_valid = 1'b1;
        bus.in_data = 16'hB000;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL collapse_accept: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (stage_valid !== 4'b1001) begin n_bad++; $display("FAIL collapse_start: got %b want 1001", stage_valid); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL collapse_in_ready c=%0d: got %b want 1", c, bus.in_ready); end
            tick();
            n_cmp++; if (stage_valid !== exp_v[c]) begin n_bad++; $display("FAIL collapse_step c=%0d: got %b want %b", c, stage_valid, exp_v[c]); end
        end
        n_cmp++; if (sd(2) !== 16'hB000 || bus.out_data !== 16'hB003) begin n_bad++; $display("FAIL collapse_data: got %h/%h want b000/b003", sd(2), bus.out_data); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 4; k++) push(16'hC000 + 16'(k));
        flush = 1'b1;
        flush_stage = 2'd1;
        hold = 4'b0010;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hC004;
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_block: got in_ready %b want 0", bus.in_ready); end
        tick();
        flush = 1'b0; hold = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        n_cmp++; if (stage_valid !== 4'b1000 || bus.out_data !== 16'hC001) begin n_bad++; $display("FAIL flush_range: got %b/%h want 1000/c001", stage_valid, bus.out_data); end

        do_reset();
        for (int k = 0; k < 4; k++) push(16'hC010 + 16'(k));
        flush = 1'b1;
        flush_stage = 2'd3;
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b0; bus.out_ready = 1'b0;
        n_cmp++; if (stage_valid !== 4'b0000) begin n_bad++; $display("FAIL flush_all: got %b want 0000", stage_valid); end
    endtask

    task automatic test_saturate();
        do_reset();
        sbus.in_valid = 1'b1;
        sbus.in_data = 16'hD000;
        repeat (18) tick();
        n_cmp++; if (s_stall !== 4'hE) begin n_bad++; $display("FAIL sat_count: got %h want e", s_stall); end
        repeat (12) tick();
        n_cmp++; if (s_stall !== 4'hF) begin n_bad++; $display("FAIL sat_stick: got %h want f", s_stall); end
        n_cmp++; if (s_bubble !== 4'h0) begin n_bad++; $display("FAIL sat_bubble: got %h want 0", s_bubble); end
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        n_cmp++; if (s_stall !== 4'h0) begin n_bad++; $display("FAIL sat_clear: got %h want 0", s_stall); end
        sbus.in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) push(16'hE000 + 16'(k));
        n_cmp++; if (stage_valid !== 4'b0111 || bubble_cnt !== 16'd3) begin n_bad++; $display("FAIL areset_pre: got %b/%0d want 0111/3", stage_valid, bubble_cnt); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (stage_valid !== 4'b0000 || stage_data !== 64'h0) begin n_bad++; $display("FAIL areset_now: got %b/%h want 0000/0", stage_valid, stage_data); end
        n_cmp++; if (bubble_cnt !== 16'd0 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_cnt: got %0d/%b want 0/0", bubble_cnt, bus.out_valid); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.out_ready = 1'b0;
        hold = '0; flush = 1'b0; flush_stage = '0; clr_cnt = 1'b0; s_clr = 1'b0;
        tick();
        test_reset();
        test_stream();
        test_hold();
        test_collapse();
        test_flush();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
